// File: rtl/compressor_16_if.sv
// Streaming bus between an FP32 producer, the 16-bit compressor and its consumer.
// The master side drives input words and output back-pressure; the slave is the compressor.
interface compressor_16_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/compressor_16.sv
// Streaming FP32 -> 16-bit code word compressor.
// Code word {s, c[14:0]}: c==0 is +/-1.0, otherwise the leading one of c is a marker and
// the bits below it are the payload, so the magnitude is exactly c * 2^-15.
// Stage 1 classifies the float and registers its fields; stage 2 packs (and optionally
// rounds) the code word. Each stage has its own valid bit and a ready chained from the
// output, giving one word per cycle when out_ready stays high.
module compressor_16 #(
  parameter bit          ROUND_EN = 1'b1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  compressor_16_if.slave   bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] unf_cnt
);

  // How a float maps onto the code space.
  typedef enum logic [1:0] {
    CLS_NORM,   // 2^-15 <= |x| < 1.0, needs packing
    CLS_ONE,    // exactly +/-1.0
    CLS_OVF,    // |x| > 1.0, Inf or NaN: clamp to +/-1.0
    CLS_UNF     // |x| < 2^-15, zero or denormal: clamp to +/-2^-15
  } cls_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Handshake chain
  // ---------------------------------------------------------------------------
  logic v1, v2;
  logic rdy1, rdy2;

  assign rdy2         = !v2 || bus.out_ready;
  assign rdy1         = !v1 || rdy2;
  assign bus.in_ready = rdy1;

  // ---------------------------------------------------------------------------
  // Stage 1: classify
  // ---------------------------------------------------------------------------
  logic        in_s;
  logic [7:0]  in_e;
  logic [22:0] in_m;
  cls_e        in_cls;
  logic [3:0]  in_n;

  assign {in_s, in_e, in_m} = bus.in_data;

  // Payload length: e=112 gives a marker-only code, e=126 gives 14 payload bits.
  assign in_n = 4'(in_e - 8'd112);

  // Decide which region of the code space the incoming float falls into.
  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    in_cls = CLS_NORM;
    if (in_e == 8'hFF || in_e > 8'd127 || (in_e == 8'd127 && in_m != '0)) begin
      in_cls = CLS_OVF;
    end else if (in_e == 8'd127) begin
      in_cls = CLS_ONE;
    end else if (in_e < 8'd112) begin
      in_cls = CLS_UNF;
    end
  end

  logic        s1;
  cls_e        cls1;
  logic [3:0]  n1;
  logic [22:0] m1;

  // Stage 1 occupancy: reloads whenever the stage can hand its word on (or is empty).
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
    end else if (rdy1) begin
      v1 <= bus.in_valid;
    end
  end

  // Stage 1 payload registers, captured on an accepted input word.
  // NOTE: datapath registers are qualified by v1 downstream, so they carry no reset.
  always_ff @(posedge clk) begin
    if (bus.in_valid && rdy1) begin
      s1   <= in_s;
      cls1 <= in_cls;
      n1   <= in_n;
      m1   <= in_m;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: pack and round
  // ---------------------------------------------------------------------------
  logic [4:0]  n1_x;
  logic [4:0]  pay_sh;
  logic [4:0]  grd_idx;
  logic [14:0] raw_c;
  logic        grd;
  logic [22:0] stk_mask;
  logic        stk;
  logic        inc;
  logic [15:0] sum;
  logic [14:0] rnd_c;

  assign n1_x     = {1'b0, n1};
  assign pay_sh   = 5'd23 - n1_x;     // drop all but the top n mantissa bits
  assign grd_idx  = 5'd22 - n1_x;     // first mantissa bit below the payload
  assign raw_c    = (15'd1 << n1) | 15'(m1 >> pay_sh);
  assign grd      = m1[grd_idx];
  assign stk_mask = (23'd1 << grd_idx) - 23'd1;
  assign stk      = |(m1 & stk_mask);

  // Round-to-nearest-even on the code word; a carry into bit 15 means the value rounded
  // up to 1.0, which is encoded as c==0. A carry into the marker position simply moves
  // the marker up one place, which is the correct next binade.
  always_comb begin
    inc   = ROUND_EN && grd && (stk || raw_c[0]);
    sum   = {1'b0, raw_c} + 16'(inc);
    rnd_c = sum[15] ? 15'h0000 : sum[14:0];
  end

  logic [14:0] pk_code;
  logic [1:0]  pk_flags;

  // Select the packed code and flags; clamped words bypass rounding.
  always_comb begin
    pk_code  = 15'h0000;
    pk_flags = 2'b00;
    unique case (cls1)
      CLS_OVF: begin
        pk_code  = 15'h0000;
        pk_flags = 2'b10;
      end
      CLS_ONE: begin
        pk_code  = 15'h0000;
        pk_flags = 2'b00;
      end
      CLS_UNF: begin
        pk_code  = 15'h0001;
        pk_flags = 2'b01;
      end
      default: begin
        pk_code  = rnd_c;
        pk_flags = 2'b00;
      end
    endcase
  end

  logic [15:0] out_data_q;
  logic [1:0]  out_flags_q;

  // Output register: holds its word while the consumer stalls, reloads when it can advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2          <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else if (rdy2) begin
      v2 <= v1;
      if (v1) begin
        out_data_q  <= {s1, pk_code};
        out_flags_q <= pk_flags;
      end
    end
  end

  assign bus.out_valid = v2;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;

  // ---------------------------------------------------------------------------
  // Event counters
  // ---------------------------------------------------------------------------
  logic out_fire;

  assign out_fire = v2 && bus.out_ready;

  // Count delivered overflow words; saturate, clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_fire && out_flags_q[1] && ovf_cnt != CNT_MAX) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

  // Count delivered underflow words; saturate, clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      unf_cnt <= '0;
    end else if (out_fire && out_flags_q[0] && unf_cnt != CNT_MAX) begin
      unf_cnt <= unf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_compressor_16.sv
// Bench for compressor_16: two instances fed the same stream, one rounding with 2-bit
// counters, one truncating with 16-bit counters. Expected codes come from |x| * 2^15
// rounded (or truncated); outputs are also decoded back and compared with the input.
module tb_compressor_16;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic cnt_clr = 1'b0;
  int   cyc     = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  compressor_16_if if_a ();
  compressor_16_if if_b ();

  logic [1:0]  ovf_a, unf_a;
  logic [15:0] ovf_b, unf_b;

  compressor_16 #(.ROUND_EN(1'b1), .CNT_W(2)) dut_a (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_a),
    .cnt_clr (cnt_clr),
    .ovf_cnt (ovf_a),
    .unf_cnt (unf_a)
  );

  compressor_16 #(.ROUND_EN(1'b0), .CNT_W(16)) dut_b (
    .clk     (clk),
    .rst     (rst),
    .bus     (if_b),
    .cnt_clr (cnt_clr),
    .ovf_cnt (ovf_b),
    .unf_cnt (unf_b)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] cap;   // edge count at which the word was captured
  } item_t;

  item_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    n_out = 0;
  int    m_ovf_a = 0, m_unf_a = 0, m_ovf_b = 0, m_unf_b = 0;

  localparam int SAT_A = 3;
  localparam int SAT_B = 65535;

  logic [31:0] stall_w [6] = '{32'h3F000000, 32'hBE800000, 32'h3F7FFFFF,
                               32'h00000000, 32'h7F800000, 32'h38400000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic real scale2(input real v, input int p);
    real r;
    r = v;
    if (p > 0) for (int i = 0; i < p; i++) r = r * 2.0;
    else       for (int i = 0; i < -p; i++) r = r / 2.0;
    return r;
  endfunction

  // Reference: magnitude of a normal-range float is exactly code * 2^-15.
  function automatic void model(input logic [31:0] w, output logic [15:0] c_rne,
                                output logic [15:0] c_trn, output logic [1:0] fl,
                                output real x);
    logic        s;
    int          e;
    int          m;
    real         t;
    int          lo, up;
    s = w[31];
    e = int'(w[30:23]);
    m = int'(w[22:0]);
    x = 1.0;
    fl = 2'b00;
    c_rne = {s, 15'h0000};
    c_trn = {s, 15'h0000};
    if (e == 255 || e > 127 || (e == 127 && m != 0)) begin
      fl = 2'b10;
    end else if (e == 127) begin
      fl = 2'b00;
    end else if (e < 112) begin
      fl = 2'b01;
      c_rne = {s, 15'h0001};
      c_trn = {s, 15'h0001};
    end else begin
      x  = scale2(real'(m) + 8388608.0, e - 150);
      t  = x * 32768.0;
      lo = $rtoi(t);
      up = lo;
      if ((t - real'(lo)) > 0.5 || ((t - real'(lo)) == 0.5 && (lo % 2) == 1)) up = lo + 1;
      c_trn = {s, 15'(lo)};
      c_rne = {s, (up == 32768) ? 15'h0000 : 15'(up)};
    end
  endfunction

  // Decoder following the code-word definition: marker position and payload.
  function automatic real decode(input logic [15:0] w);
    logic [14:0] c;
    int          p;
    int          pay;
    c = w[14:0];
    if (c == 15'h0000) return 1.0;
    p = 0;
    for (int i = 0; i < 15; i++) if (c[i]) p = i;
    pay = int'(c) - (1 << p);
    return scale2(1.0 + scale2(real'(pay), -p), -(15 - p));
  endfunction

  function automatic logic [31:0] rand_word();
    int          r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = $urandom;
    if (r <= 5)      w[30:23] = 8'($urandom_range(112, 126));
    else if (r == 6) w[30:0]  = 31'h3F800000;
    else if (r == 7) w[30:23] = 8'd127;
    else if (r == 8) w[30:23] = 8'($urandom_range(0, 111));
    return w;
  endfunction

  function automatic logic head_visible();
    return q.size() > 0 && (cyc - int'(q[0].cap)) >= 1;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic clr);
    if_a.in_valid  = iv;
    if_a.in_data   = d;
    if_a.out_ready = ordy;
    if_b.in_valid  = iv;
    if_b.in_data   = d;
    if_b.out_ready = ordy;
    cnt_clr        = clr;
  endtask

  // One clock cycle: drive at the falling edge, compare just after, update the model.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic clr, output logic acc);
    logic        exp_rdy, exp_ov, fire;
    logic [15:0] c_rne, c_trn;
    logic [1:0]  fl;
    real         x, err;
    @(negedge clk);
    drive(iv, d, ordy, clr);
    #1;
    check("ovf_cnt_a", 32'(ovf_a), m_ovf_a);
    check("unf_cnt_a", 32'(unf_a), m_unf_a);
    check("ovf_cnt_b", 32'(ovf_b), m_ovf_b);
    check("unf_cnt_b", 32'(unf_b), m_unf_b);
    exp_rdy = (q.size() < 2) || ordy;
    exp_ov  = head_visible();
    check("in_ready_a", 32'(if_a.in_ready), 32'(exp_rdy));
    check("in_ready_b", 32'(if_b.in_ready), 32'(exp_rdy));
    check("out_valid_a", 32'(if_a.out_valid), 32'(exp_ov));
    check("out_valid_b", 32'(if_b.out_valid), 32'(exp_ov));
    fire = exp_ov && ordy;
    acc  = iv && exp_rdy;
    if (exp_ov) begin
      model(q[0].word, c_rne, c_trn, fl, x);
      check("out_data_rne", 32'(if_a.out_data), 32'(c_rne));
      check("out_data_trn", 32'(if_b.out_data), 32'(c_trn));
      check("out_flags_a", 32'(if_a.out_flags), 32'(fl));
      check("out_flags_b", 32'(if_b.out_flags), 32'(fl));
      if (fire && fl == 2'b00) begin
        err = decode(if_a.out_data) - x;
        if (err < 0.0) err = -err;
        check("err_rne_half_ulp", 32'(err <= 1.0 / 65536.0), 32'd1);
        err = decode(if_b.out_data) - x;
        if (err < 0.0) err = -err;
        check("err_trn_one_ulp", 32'(err < 1.0 / 32768.0), 32'd1);
      end
      if (clr) begin
        m_ovf_a = 0; m_unf_a = 0; m_ovf_b = 0; m_unf_b = 0;
      end else if (fire) begin
        if (fl[1] && m_ovf_a < SAT_A) m_ovf_a++;
        if (fl[0] && m_unf_a < SAT_A) m_unf_a++;
        if (fl[1] && m_ovf_b < SAT_B) m_ovf_b++;
        if (fl[0] && m_unf_b < SAT_B) m_unf_b++;
      end
    end else if (clr) begin
      m_ovf_a = 0; m_unf_a = 0; m_ovf_b = 0; m_unf_b = 0;
    end
    if (fire) begin
      void'(q.pop_front());
      n_out++;
    end
    if (acc) q.push_back('{word: d, cap: 32'(cyc + 1)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_ovf_a = 0; m_unf_a = 0; m_ovf_b = 0; m_unf_b = 0;
    #1;
    check("rst_out_valid_a", 32'(if_a.out_valid), 32'd0);
    check("rst_out_valid_b", 32'(if_b.out_valid), 32'd0);
    check("rst_out_data_a", 32'(if_a.out_data), 32'd0);
    check("rst_out_flags_a", 32'(if_a.out_flags), 32'd0);
    check("rst_in_ready_a", 32'(if_a.in_ready), 32'd1);
    check("rst_in_ready_b", 32'(if_b.in_ready), 32'd1);
    check("rst_unf_cnt_a", 32'(unf_a), 32'd0);
    check("rst_ovf_cnt_b", 32'(ovf_b), 32'd0);
  endtask

  task automatic send(input logic [31:0] w, input logic ordy);
    logic acc;
    int   budget;
    acc    = 1'b0;
    budget = 40;
    while (!acc && budget > 0) begin
      cycle(1'b1, w, ordy, 1'b0, acc);
      budget--;
    end
    check("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic acc;
    int   budget;
    budget = 40;
    while (q.size() > 0 && budget > 0) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
      budget--;
    end
    check({tag, "_drain_left"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic        acc;
    logic [31:0] pend;
    logic        have;
    int          idx, stall_acc, n0, budget;

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    do_reset();

    // Directed values: exact, clamped, boundary and rounding cases.
    send(32'h3F800000, 1'b1);
    send(32'hBF400000, 1'b1);
    send(32'h37800000, 1'b1);
    send(32'h00000000, 1'b1);
    send(32'h7F800000, 1'b1);
    send(32'hC0000000, 1'b1);
    send(32'h38400000, 1'b1);
    send(32'h3F7FFFFF, 1'b1);
    send(32'h38000000, 1'b1);
    send(32'h7FC00000, 1'b1);
    send(32'h3F800001, 1'b1);
    send(32'h80000000, 1'b1);
    send(32'h3F000000, 1'b1);
    send(32'h387FFFFF, 1'b1);
    drain("directed");

    // Back-pressure: consumer stalls for three cycles while six words are offered.
    n0        = n_out;
    idx       = 0;
    stall_acc = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      cycle(1'b1, stall_w[idx], (c >= 3), 1'b0, acc);
      if (acc) begin
        idx++;
        if (c < 3) stall_acc++;
      end
    end
    check("stall_accepted_while_blocked", 32'(stall_acc), 32'd2);
    check("stall_all_accepted", 32'(idx), 32'd6);
    drain("stall");
    check("stall_out_count", 32'(n_out - n0), 32'd6);

    // Random stream with random valid gaps and back-pressure.
    have = 1'b0;
    pend = 32'h0;
    for (int i = 0; i < 600; i++) begin
      if (!have) begin
        pend = rand_word();
        have = 1'b1;
      end
      cycle(($urandom_range(0, 3) != 0), pend, ($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) have = 1'b0;
    end
    drain("random");

    // Counter saturation at 2^CNT_W-1 on the narrow instance.
    cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
    send(32'h00000000, 1'b1);
    send(32'h80000001, 1'b1);
    send(32'h37800000, 1'b1);
    send(32'h00800000, 1'b1);
    send(32'hB7FFFFFF, 1'b1);
    drain("unf_burst");
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    check("unf_cnt_saturated_a", 32'(unf_a), 32'd3);
    check("unf_cnt_wide_b", 32'(unf_b), 32'd5);

    // Clear in the same cycle as an underflow word is delivered.
    send(32'h00000000, 1'b0);
    budget = 10;
    while (!head_visible() && budget > 0) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0, acc);
      budget--;
    end
    check("clr_word_visible", 32'(head_visible()), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, acc);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    check("clr_priority_unf_a", 32'(unf_a), 32'd0);
    check("clr_priority_unf_b", 32'(unf_b), 32'd0);

    // Reset with words in flight, then confirm the pipe still works.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3F000000, 1'b0, 1'b0, acc);
    do_reset();
    send(32'h3F400000, 1'b1);
    send(32'hB8400000, 1'b1);
    drain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
